// File: rtl/wbctrl_pkg.sv
// Shared types and constants for the Wishbone control/SRAM bridge.
// Optional SRAM timeout is enabled with WBCTRL_TIMEOUT_EN.
package wbctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DECODE,
      ST_MEM_WAIT,
      ST_RESP
   } state_t;

   localparam logic [1:0] MEM_OP_IDLE  = 2'b00;
   localparam logic [1:0] MEM_OP_READ  = 2'b01;
   localparam logic [1:0] MEM_OP_WRITE = 2'b11;

   localparam int CSR_OPERATION = 0;
   localparam int CSR_STATUS    = 1;

endpackage

// File: rtl/wbctrl_csr_bank.sv
// CSR bank: byte-masked writes, status clear on finished, read mux,
// flattened bank output and registered status interrupt.
module wbctrl_csr_bank
   import wbctrl_pkg::*;
#(
   parameter int NUM_REGS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_we,
   input  logic [3:0]              i_idx,
   input  logic [3:0]              i_sel,
   input  logic [31:0]             i_wdata,
   input  logic                    i_finished,
   output logic [31:0]             o_rdata,
   output logic [32*NUM_REGS-1:0]  o_csr,
   output logic                    o_irq
);

   logic [31:0] r_csr [NUM_REGS];
   logic        r_irq;
   logic [31:0] w_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_csr[i] <= '0;
         r_irq <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++)
            for (int b = 0; b < 4; b++)
               if (i_we && i_idx == 4'(i) && i_sel[b])
                  r_csr[i][8*b +: 8] <= i_wdata[8*b +: 8];
         // core completion wins over a same-cycle bus write
         if (i_finished)
            r_csr[CSR_STATUS] <= '0;
         r_irq <= |r_csr[CSR_STATUS];
      end
   end

   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (i_idx == 4'(i))
            w_rdata = r_csr[i];
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign o_csr[32*g +: 32] = r_csr[g];
   end

   assign o_rdata = w_rdata;
   assign o_irq   = r_irq;

endmodule

// File: rtl/wbctrl_regfile.sv
// Wishbone B4 classic slave: CSR bank plus forwarded SRAM window.
// Define WBCTRL_TIMEOUT_EN to bound the SRAM wait with an error.
module wbctrl_regfile
   import wbctrl_pkg::*;
#(
   parameter logic [31:0] ADDR_OFFSET    = 32'h3200_0000,
   parameter int          NUM_REGS       = 4,
   parameter int          SRAM_AWIDTH    = 8,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_ni,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_we_i,
   input  logic [3:0]              wb_sel_i,
   input  logic [31:0]             wb_adr_i,
   input  logic [31:0]             wb_data_i,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic [31:0]             wb_data_o,
   input  logic                    finished_i,
   output logic [1:0]              mem_op_o,
   output logic [SRAM_AWIDTH-1:0]  mem_addr_o,
   output logic [31:0]             mem_wdata_o,
   output logic [3:0]              mem_be_o,
   input  logic                    mem_opdone_i,
   input  logic [31:0]             mem_rdata_i,
   output logic [32*NUM_REGS-1:0]  csr_o,
   output logic                    irq_o
);

   localparam logic [31:0] CSR_BYTES = 32'(4 * NUM_REGS);

   state_t                  r_state;
   logic [31:0]             r_adr;
   logic [31:0]             r_wdat;
   logic [3:0]              r_sel;
   logic                    r_we;
   logic                    r_ack;
   logic                    r_err;
   logic [31:0]             r_dat;
   logic [1:0]              r_op;
   logic [SRAM_AWIDTH-1:0]  r_maddr;
   logic [31:0]             r_mwdata;
   logic [3:0]              r_be;
   logic                    r_abort;

   logic [31:0]             w_off;
   logic [29:0]             w_word;
   logic                    w_mis;
   logic                    w_is_csr;
   logic                    w_oor;
   logic                    w_bad;
   logic                    w_csr_we;
   logic                    w_drop;
   logic [31:0]             w_csr_rd;

   // modular offset: addresses below the base wrap to huge words
   assign w_off    = r_adr - ADDR_OFFSET;
   assign w_mis    = |w_off[1:0];
   assign w_is_csr = w_off < CSR_BYTES;
   assign w_word   = w_off[31:2] - 30'(NUM_REGS);
   assign w_oor    = ({2'b00, w_word} >> SRAM_AWIDTH) != 32'd0;
   assign w_bad    = w_mis || (!w_is_csr && w_oor);
   assign w_drop   = r_abort || !wb_cyc_i;
   assign w_csr_we = (r_state == ST_DECODE) && wb_cyc_i && r_we
                     && !w_bad && w_is_csr;

`ifdef WBCTRL_TIMEOUT_EN
   logic [7:0] r_tmo;
   logic       w_tmo;
   assign w_tmo = (r_tmo == 8'(TIMEOUT_CYCLES - 1));
`endif

   wbctrl_csr_bank #(
      .NUM_REGS   (NUM_REGS)
   ) u_csr (
      .clk        (wb_clk_i),
      .rst_n      (wb_rst_ni),
      .i_we       (w_csr_we),
      .i_idx      (w_off[5:2]),
      .i_sel      (r_sel),
      .i_wdata    (r_wdat),
      .i_finished (finished_i),
      .o_rdata    (w_csr_rd),
      .o_csr      (csr_o),
      .o_irq      (irq_o)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state  <= ST_IDLE;
         r_adr    <= '0;
         r_wdat   <= '0;
         r_sel    <= '0;
         r_we     <= 1'b0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
         r_dat    <= '0;
         r_op     <= MEM_OP_IDLE;
         r_maddr  <= '0;
         r_mwdata <= '0;
         r_be     <= '0;
         r_abort  <= 1'b0;
`ifdef WBCTRL_TIMEOUT_EN
         r_tmo    <= '0;
`endif
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  r_adr   <= wb_adr_i;
                  r_wdat  <= wb_data_i;
                  r_sel   <= wb_sel_i;
                  r_we    <= wb_we_i;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_abort <= 1'b0;
               if (!wb_cyc_i) begin
                  r_state <= ST_IDLE;
               end else if (w_bad) begin
                  r_err   <= 1'b1;
                  r_dat   <= '0;
                  r_state <= ST_RESP;
               end else if (w_is_csr) begin
                  r_ack   <= 1'b1;
                  r_dat   <= r_we ? 32'd0 : w_csr_rd;
                  r_state <= ST_RESP;
               end else begin
                  r_op     <= r_we ? MEM_OP_WRITE : MEM_OP_READ;
                  r_maddr  <= w_word[SRAM_AWIDTH-1:0];
                  r_mwdata <= r_wdat;
                  r_be     <= r_sel;
`ifdef WBCTRL_TIMEOUT_EN
                  r_tmo    <= '0;
`endif
                  r_state  <= ST_MEM_WAIT;
               end
            end
            ST_MEM_WAIT: begin
               // an aborted cycle still lets the SRAM op finish
               if (!wb_cyc_i)
                  r_abort <= 1'b1;
               if (mem_opdone_i) begin
                  r_op  <= MEM_OP_IDLE;
                  r_dat <= r_we ? 32'd0 : mem_rdata_i;
                  if (w_drop) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_ack   <= 1'b1;
                     r_state <= ST_RESP;
                  end
               end
`ifdef WBCTRL_TIMEOUT_EN
               else if (w_tmo) begin
                  r_op  <= MEM_OP_IDLE;
                  r_dat <= '0;
                  if (w_drop) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= ST_RESP;
                  end
               end else begin
                  r_tmo <= r_tmo + 8'd1;
               end
`endif
            end
            ST_RESP: begin
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign wb_ack_o    = r_ack;
   assign wb_err_o    = r_err;
   assign wb_data_o   = r_dat;
   assign mem_op_o    = r_op;
   assign mem_addr_o  = r_maddr;
   assign mem_wdata_o = r_mwdata;
   assign mem_be_o    = r_be;

endmodule

// File: tb/tb_wbctrl_regfile.sv
// Directed scoreboard bench for wbctrl_regfile (default parameters).
module tb_wbctrl_regfile;

   localparam logic [31:0] BASE = 32'h3200_0000;
   localparam int NREGS = 4;
   localparam int AW    = 8;
   localparam int TMO   = 16;
   localparam int LIMIT = 40;

   typedef struct {
      logic        err;
      logic        mem;
      logic [31:0] data;
      int          lat;
      logic [1:0]  op;
      logic [7:0]  addr;
   } exp_t;

   logic              clk = 0;
   logic              rst_n = 0;
   logic              cyc = 0, stb = 0, we = 0;
   logic [3:0]        sel = 0;
   logic [31:0]       adr = 0, wdat = 0;
   logic              ack, err;
   logic [31:0]       rdat;
   logic              fin = 0;
   logic [1:0]        mop;
   logic [AW-1:0]     maddr;
   logic [31:0]       mwdata;
   logic [3:0]        mbe;
   logic              opdone = 0;
   logic [31:0]       mrdata = 0;
   logic [32*NREGS-1:0] csr;
   logic              irq;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   logic [31:0] exp_csr [NREGS];

   always #5 clk = ~clk;

   wbctrl_regfile #(
      .ADDR_OFFSET    (BASE),
      .NUM_REGS       (NREGS),
      .SRAM_AWIDTH    (AW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .wb_cyc_i     (cyc),
      .wb_stb_i     (stb),
      .wb_we_i      (we),
      .wb_sel_i     (sel),
      .wb_adr_i     (adr),
      .wb_data_i    (wdat),
      .wb_ack_o     (ack),
      .wb_err_o     (err),
      .wb_data_o    (rdat),
      .finished_i   (fin),
      .mem_op_o     (mop),
      .mem_addr_o   (maddr),
      .mem_wdata_o  (mwdata),
      .mem_be_o     (mbe),
      .mem_opdone_i (opdone),
      .mem_rdata_i  (mrdata),
      .csr_o        (csr),
      .irq_o        (irq)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [127:0] flat();
      logic [127:0] f;
      f = '0;
      for (int i = 0; i < NREGS; i++)
         f[32*i +: 32] = exp_csr[i];
      return f;
   endfunction

   task automatic xfer(input string tag, input logic [31:0] a,
                       input logic w, input logic [3:0] s,
                       input logic [31:0] d, input int dly,
                       input logic [31:0] rd, input logic f);
      exp_t e, g;
      logic [31:0] off, word;
      int cnt, idx;
      bit done, seen;
      off  = a - BASE;
      word = {2'b00, off[31:2]} - 32'(NREGS);
      e.err = 0; e.mem = 0; e.data = 0; e.lat = 2;
      e.op = w ? 2'b11 : 2'b01;
      e.addr = word[7:0];
      if (off[1:0] != 2'b00) begin
         e.err = 1;
      end else if (off < 32'(4*NREGS)) begin
         idx = int'(off[5:2]);
         if (w) begin
            for (int b = 0; b < 4; b++)
               if (s[b]) exp_csr[idx][8*b +: 8] = d[8*b +: 8];
         end else begin
            e.data = exp_csr[idx];
         end
      end else if (word >= 32'(1 << AW)) begin
         e.err = 1;
      end else begin
         e.mem = 1;
         e.lat = dly + 2;
         if (!w) e.data = rd;
`ifdef WBCTRL_TIMEOUT_EN
         if (dly == 0) begin
            e.err = 1; e.lat = 2 + TMO; e.data = 0;
         end
`endif
      end
      if (f) exp_csr[1] = '0;
      sb.push_back(e);
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = w; sel = s; adr = a; wdat = d;
      cnt = 0; done = 0; seen = 0;
      for (int k = 0; k < LIMIT && !done; k++) begin
         @(negedge clk);
         opdone = 0;
         fin = f && (k == 1);
         if (ack || err) begin
            g = sb.pop_front();
            done = 1;
            chk({tag, " err"}, err, g.err);
            chk({tag, " ack"}, ack, !g.err);
            chk({tag, " latency"}, k, g.lat);
            if (!w) chk({tag, " rdata"}, rdat, g.data);
            chk({tag, " mem used"}, seen, g.mem);
            chk({tag, " op idle"}, mop, 2'b00);
            chk({tag, " csr_o"}, csr, flat());
         end else if (mop != 2'b00) begin
            cnt++;
            if (cnt == 1) begin
               seen = 1;
               chk({tag, " mem_op"}, mop, e.op);
               chk({tag, " mem_addr"}, maddr, e.addr);
               chk({tag, " mem_be"}, mbe, s);
               if (w) chk({tag, " mem_wdata"}, mwdata, d);
            end
            if (cnt == dly) begin
               opdone = 1;
               mrdata = rd;
            end
         end
      end
      opdone = 0;
      fin = 0;
      chk({tag, " response seen"}, done, 1'b1);
      @(posedge clk); #1;
      cyc = 0; stb = 0; we = 0;
   endtask

   initial begin
      bit seen, bad;
      for (int i = 0; i < NREGS; i++) exp_csr[i] = '0;

      repeat (3) @(negedge clk);
      chk("rst ack", ack, 0);
      chk("rst err", err, 0);
      chk("rst data", rdat, 0);
      chk("rst op", mop, 0);
      chk("rst addr", maddr, 0);
      chk("rst wdata", mwdata, 0);
      chk("rst be", mbe, 0);
      chk("rst csr", csr, 0);
      chk("rst irq", irq, 0);
      rst_n = 1;

      xfer("wr csr0", 32'h3200_0000, 1, 4'hF, 32'hDEAD_BEEF, 0, 0, 0);
      xfer("rd csr0", 32'h3200_0000, 0, 4'hF, 0, 0, 0, 0);
      xfer("wr status", 32'h3200_0004, 1, 4'b0101, 32'h1122_3344, 0, 0, 0);
      chk("irq set", irq, 1);
      xfer("rd status", 32'h3200_0004, 0, 4'hF, 0, 0, 0, 0);
      xfer("wr csr3", 32'h3200_000C, 1, 4'b1000, 32'hA5A5_A5A5, 0, 0, 0);
      xfer("wr sel0", 32'h3200_0008, 1, 4'h0, 32'hFFFF_FFFF, 0, 0, 0);
      xfer("fin race", 32'h3200_0004, 1, 4'hF, 32'hFFFF_FFFF, 0, 0, 1);
      chk("irq clr", irq, 0);

      xfer("sram wr", 32'h3200_0014, 1, 4'hF, 32'hCAFE_0001, 3, 0, 0);
      xfer("sram rd", 32'h3200_0010, 0, 4'hF, 0, 1, 32'h0000_ABCD, 0);
      xfer("sram last", 32'h3200_040C, 0, 4'h3, 0, 2, 32'h1234_5678, 0);

      xfer("err mis", 32'h3200_0002, 1, 4'hF, 32'h5555_5555, 0, 0, 0);
      xfer("err below", 32'h31FF_FFFC, 0, 4'hF, 0, 0, 0, 0);
      xfer("err above", 32'h3200_0410, 0, 4'hF, 0, 0, 0, 0);
      xfer("err mis sram", 32'h3200_0011, 0, 4'hF, 0, 0, 0, 0);

      // stray completion while idle
      @(negedge clk); opdone = 1; mrdata = 32'hFFFF_FFFF;
      @(negedge clk); opdone = 0;
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (ack || err || mop != 2'b00) bad = 1;
      end
      chk("stray opdone", bad, 0);

      // master abandons the cycle during the SRAM wait
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3200_0018;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (mop == 2'b01) seen = 1;
      end
      chk("drop op started", seen, 1);
      chk("drop addr", maddr, 8'd2);
      cyc = 0; stb = 0;
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ack || err) bad = 1;
         if (k == 1) chk("drop op held", mop, 2'b01);
         opdone = (k == 2);
      end
      opdone = 0;
      chk("drop no resp", bad, 0);
      chk("drop op idle", mop, 2'b00);
      xfer("after drop", 32'h3200_0000, 0, 4'hF, 0, 0, 0, 0);

`ifdef WBCTRL_TIMEOUT_EN
      xfer("timeout", 32'h3200_0010, 0, 4'hF, 0, 0, 0, 0);
      @(negedge clk); opdone = 1;
      @(negedge clk); opdone = 0;
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (ack || err) bad = 1;
      end
      chk("late opdone", bad, 0);
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3200_0010;
      repeat (4) @(negedge clk);
      cyc = 0; stb = 0;
      bad = 0;
      for (int k = 0; k < TMO + 6; k++) begin
         @(negedge clk);
         if (ack || err) bad = 1;
      end
      chk("tmo drop no resp", bad, 0);
      chk("tmo drop op idle", mop, 2'b00);
`endif

      // reset while an SRAM write is outstanding
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 1; sel = 4'hF;
      adr = 32'h3200_0014; wdat = 32'h0BAD_F00D;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (mop == 2'b11) seen = 1;
      end
      chk("rst op started", seen, 1);
      rst_n = 0;
      #1;
      chk("rst async op", mop, 2'b00);
      chk("rst async ack", ack, 0);
      for (int i = 0; i < NREGS; i++) exp_csr[i] = '0;
      chk("rst async csr", csr, flat());
      cyc = 0; stb = 0; we = 0;
      @(negedge clk);
      rst_n = 1;
      xfer("rd after rst", 32'h3200_0000, 0, 4'hF, 0, 0, 0, 0);

      chk("scoreboard empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
